spy_readout_sequencer: RTL
==========================

// Module: spy_readout_sequencer
// PURPOSE
//  Sequences a freeze-and-dump of one SpyBuffer's spy side in the write-clock domain.
//  On start: asserts freeze and waits for the spy write path to settle.
//  Then snapshots the spy and metadata write pointers.
//  Then reads every spy memory row (oldest first), then every metadata row, into a valid/ready stream.
//  Sits between the SpyBuffer spy ports and the board readout/block-transfer logic.
// PARAMETERS
//  DATA_WIDTH     32  spy word is DATA_WIDTH+1 bits (data + metadata bit)
//  SPY_MEM_WIDTH  7   spy memory address width; 2**SPY_MEM_WIDTH rows
//  EL_MEM_WIDTH   4   event-list address width; 2**EL_MEM_WIDTH rows
//  SETTLE_CYCLES  4   cycles freeze is held before pointer snapshot (>=1)
// PORTS
//  clock                 in   1                  spy-side (write) clock
//  reset                 in   1                  asynchronous, active-high
//  start                 in   1                  begin dump; sampled only in IDLE
//  abort                 in   1                  cancel dump; wins over everything except reset
//  freeze                out  1                  to SpyBuffer freeze
//  spy_write_addr        in   SPY_MEM_WIDTH      spy memory write pointer (next row to write)
//  spy_meta_write_addr   in   EL_MEM_WIDTH       metadata write pointer
//  spy_read_enable       out  1                  spy memory read strobe
//  spy_read_addr         out  SPY_MEM_WIDTH      spy memory read address
//  spy_data              in   DATA_WIDTH+1       spy read data, valid 1 cycle after strobe
//  spy_meta_read_enable  out  1                  metadata read strobe
//  spy_meta_read_addr    out  EL_MEM_WIDTH       metadata read address
//  spy_meta_read_data    in   SPY_MEM_WIDTH+1    metadata read data, valid 1 cycle after strobe
//  out_data              out  DATA_WIDTH+1       dump word; metadata is zero-extended
//  out_is_meta           out  1                  out_data is a metadata row
//  out_last              out  1                  final word of the dump
//  out_valid             out  1                  out_data valid
//  out_ready             in   1                  consumer accepts when out_valid & out_ready
//  busy                  out  1                  state != IDLE
//  done                  out  1                  1-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0. Output buffer is emptied; counters are cleared.
//  States and transitions:
//   IDLE:   start=1 -> FREEZE. busy=0, freeze=0.
//   FREEZE: freeze=1. Held SETTLE_CYCLES cycles (down-counter) -> SNAP.
//   SNAP:   1 cycle. Registers d_ptr=spy_write_addr and m_ptr=spy_meta_write_addr -> DATA.
//   DATA:   issues 2**SPY_MEM_WIDTH reads at d_ptr, d_ptr+1, ... (mod 2**SPY_MEM_WIDTH).
//           After the last read is issued -> META.
//   META:   issues 2**EL_MEM_WIDTH reads at m_ptr, m_ptr+1, ... (mod 2**EL_MEM_WIDTH).
//           After the last read is issued -> DRAIN.
//   DRAIN:  waits for the output buffer to empty and the last word to be accepted -> DONE.
//   DONE:   1 cycle, done=1 -> IDLE. freeze returns to 0 in IDLE.
//  freeze is 1 in FREEZE, SNAP, DATA, META, DRAIN and DONE; it is 0 otherwise.
//  Flow control:
//   - 2-entry output FIFO.
//   - A read is issued in a cycle only if (occupancy + reads in flight) < 2.
//   - Read data is written to the FIFO at the edge ending the cycle after the strobe.
//   - Latency: strobe in cycle N -> out_valid earliest in cycle N+2.
//   - out_valid=1 and out_ready=0: out_data, out_is_meta and out_last hold stable.
//   - No word is dropped or duplicated under any out_ready pattern.
//   - With out_ready held at 1: one read strobe and one accepted word per cycle.
//  out_is_meta=1 for exactly the 2**EL_MEM_WIDTH metadata words.
//  out_last=1 only on the final metadata word.
//  At most one of spy_read_enable and spy_meta_read_enable is high per cycle.
//  Read addresses are driven 0 whenever the matching strobe is low.
//  start while busy: ignored.
//  start and abort together in IDLE: abort wins and no dump starts.
//  abort (any non-IDLE state): IDLE next cycle. FIFO flushed, reads in flight discarded.
//  After abort: freeze=0, out_valid=0, no done pulse.
//  reset mid-dump: identical outcome to abort, taking effect asynchronously.
//  Pointer inputs are sampled only in SNAP; later changes are ignored.
// TESTING
//  Use SPY_MEM_WIDTH=3, EL_MEM_WIDTH=2, SETTLE_CYCLES=4.
//  1 Basic dump: spy_write_addr=2, meta_wptr=1, out_ready=1, pulse start.
//    -> freeze rises the next cycle; SNAP 4 cycles later.
//    -> spy reads addr 2,3,4,5,6,7,0,1, then meta reads 1,2,3,0.
//    -> 12 words; out_last and out_is_meta on word 12; done 1 cycle after its acceptance.
//  2 Backpressure: as 1 with out_ready toggling 1,0,0,1 repeating.
//    -> same 12 words in same order; out_data stable while stalled.
//    -> in-flight reads + occupancy never exceed 2.
//  3 Pointer wrap: spy_write_addr=0, meta_wptr=0.
//    -> spy addresses 0..7, meta addresses 0..3.
//    -> spy_write_addr changed to 5 during DATA has no effect.
//  4 Abort: assert abort after the 3rd accepted word.
//    -> IDLE next cycle; freeze=0, out_valid=0, busy=0, no done.
//    -> a new start then runs a complete 12-word dump.
//  5 Reset mid-META: assert reset.
//    -> all outputs 0 immediately (asynchronous); state IDLE after release.
//  6 start pulses during busy.
//    -> ignored: exactly one dump and one done pulse.

Source files
------------

// File: rtl/spy_readout_sequencer_if.sv
// Spy-side memory ports and the dump word stream between the sequencer (master)
// and the SpyBuffer / readout consumer (slave).
interface spy_readout_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int SPY_MEM_WIDTH = 7,
  parameter int EL_MEM_WIDTH  = 4
);
  logic [SPY_MEM_WIDTH-1:0] spy_write_addr;
  logic [EL_MEM_WIDTH-1:0]  spy_meta_write_addr;
  logic                     spy_read_enable;
  logic [SPY_MEM_WIDTH-1:0] spy_read_addr;
  logic [DATA_WIDTH:0]      spy_data;
  logic                     spy_meta_read_enable;
  logic [EL_MEM_WIDTH-1:0]  spy_meta_read_addr;
  logic [SPY_MEM_WIDTH:0]   spy_meta_read_data;
  logic [DATA_WIDTH:0]      out_data;
  logic                     out_is_meta;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  spy_write_addr, spy_meta_write_addr, spy_data, spy_meta_read_data, out_ready,
    output spy_read_enable, spy_read_addr, spy_meta_read_enable, spy_meta_read_addr,
           out_data, out_is_meta, out_last, out_valid
  );

  modport slave (
    output spy_write_addr, spy_meta_write_addr, spy_data, spy_meta_read_data, out_ready,
    input  spy_read_enable, spy_read_addr, spy_meta_read_enable, spy_meta_read_addr,
           out_data, out_is_meta, out_last, out_valid
  );
endinterface

// File: rtl/spy_readout_sequencer.sv
// Freeze-and-dump sequencer: freezes the spy buffer, snapshots write pointers, then
// streams every spy row (oldest first) followed by every metadata row.
module spy_readout_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int SPY_MEM_WIDTH = 7,
  parameter int EL_MEM_WIDTH  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic abort_i,
  output logic freeze_o,
  output logic busy_o,
  output logic done_o,
  spy_readout_sequencer_if.master bus
);
  localparam int DW       = DATA_WIDTH + 1;
  localparam int SPY_ROWS = 1 << SPY_MEM_WIDTH;
  localparam int EL_ROWS  = 1 << EL_MEM_WIDTH;
  localparam int CW       = (SPY_MEM_WIDTH > EL_MEM_WIDTH) ? SPY_MEM_WIDTH : EL_MEM_WIDTH;
  localparam int SW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_SNAP, S_DATA, S_META, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic          meta;
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            settle_q;
  logic [CW-1:0]            cnt_q;
  logic [SPY_MEM_WIDTH-1:0] d_ptr_q;
  logic [EL_MEM_WIDTH-1:0]  m_ptr_q;
  logic                     fl_q, fl_meta_q, fl_last_q;
  word_t                    fifo_q [2];
  logic                     wr_q, rd_q;
  logic [1:0]               occ_q;
  logic                     freeze_q, busy_q, done_q;

  logic  pop, credit, issue_d, issue_m, d_last, m_last;
  word_t push_word;

  always_comb begin
    pop       = (occ_q != 2'd0) && bus.out_ready;
    // a word being accepted this cycle frees its slot for a new strobe
    credit    = ({1'b0, occ_q} + {2'b0, fl_q} - {2'b0, pop}) < 3'd2;
    issue_d   = (state_q == S_DATA) && credit && !abort_i;
    issue_m   = (state_q == S_META) && credit && !abort_i;
    d_last    = cnt_q == CW'(SPY_ROWS - 1);
    m_last    = cnt_q == CW'(EL_ROWS - 1);
    push_word.meta = fl_meta_q;
    push_word.last = fl_last_q;
    push_word.data = fl_meta_q ? DW'(bus.spy_meta_read_data) : bus.spy_data;

    state_d = state_q;
    if (abort_i) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:   if (start_i) state_d = S_FREEZE;
        S_FREEZE: if (settle_q == '0) state_d = S_SNAP;
        S_SNAP:   state_d = S_DATA;
        S_DATA:   if (issue_d && d_last) state_d = S_META;
        S_META:   if (issue_m && m_last) state_d = S_DRAIN;
        S_DRAIN:  if (!fl_q && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      cnt_q     <= '0;
      d_ptr_q   <= '0;
      m_ptr_q   <= '0;
      fl_q      <= 1'b0;
      fl_meta_q <= 1'b0;
      fl_last_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      occ_q     <= 2'd0;
      freeze_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= state_d != S_IDLE;
      freeze_q <= state_d != S_IDLE;
      done_q   <= state_d == S_DONE;

      if (state_q == S_IDLE) settle_q <= SW'(SETTLE_CYCLES - 1);
      else if (state_q == S_FREEZE && settle_q != '0) settle_q <= settle_q - SW'(1);

      if (state_q == S_SNAP) begin
        d_ptr_q <= bus.spy_write_addr;
        m_ptr_q <= bus.spy_meta_write_addr;
        cnt_q   <= '0;
      end else if (issue_d) begin
        d_ptr_q <= d_ptr_q + SPY_MEM_WIDTH'(1);
        cnt_q   <= d_last ? '0 : cnt_q + CW'(1);
      end else if (issue_m) begin
        m_ptr_q <= m_ptr_q + EL_MEM_WIDTH'(1);
        cnt_q   <= cnt_q + CW'(1);
      end

      fl_q      <= issue_d | issue_m;
      fl_meta_q <= issue_m;
      fl_last_q <= issue_m && m_last;

      // abort drops buffered words and the read returning this cycle
      if (abort_i) begin
        occ_q <= 2'd0;
        wr_q  <= 1'b0;
        rd_q  <= 1'b0;
      end else begin
        if (fl_q) begin
          fifo_q[wr_q] <= push_word;
          wr_q         <= ~wr_q;
        end
        if (pop) rd_q <= ~rd_q;
        occ_q <= occ_q + {1'b0, fl_q} - {1'b0, pop};
      end
    end
  end

  assign freeze_o = freeze_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

  assign bus.spy_read_enable      = issue_d;
  assign bus.spy_read_addr        = issue_d ? d_ptr_q : '0;
  assign bus.spy_meta_read_enable = issue_m;
  assign bus.spy_meta_read_addr   = issue_m ? m_ptr_q : '0;

  assign bus.out_valid   = occ_q != 2'd0;
  assign bus.out_data    = bus.out_valid ? fifo_q[rd_q].data : '0;
  assign bus.out_is_meta = bus.out_valid & fifo_q[rd_q].meta;
  assign bus.out_last    = bus.out_valid & fifo_q[rd_q].last;
endmodule
